// File: rtl/adapter_from_bus.sv
// Receive end of the beat-serial bus: gathers BEAT_WIDTH beats up to a 'last' flag into one
// DATA_WIDTH word plus length (beats-1). Optional sticky overflow flag: ADAPTER_FROM_BUS_OVERFLOW_EN.
module adapter_from_bus #(
  parameter int DATA_WIDTH   = 128,
  parameter int BEAT_WIDTH   = 32,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    in_enq__ENA,
  input  logic [BEAT_WIDTH-1:0]   in_enq_v,
  input  logic                    in_enq_last,
  output logic                    in_enq__RDY,
  output logic                    out_enq__ENA,
  output logic [DATA_WIDTH-1:0]   out_enq_v,
  output logic [LENGTH_WIDTH-1:0] out_enq_length,
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  output logic                    overflow,
`endif
  input  logic                    out_enq__RDY
);

  localparam int WORDS = DATA_WIDTH / BEAT_WIDTH;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   buffer_q, buffer_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;
  logic                    beat_acc_s;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  logic                    ovf_q, ovf_d;
`endif

  // State register and datapath registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= COLLECT;
      buffer_q <= {DATA_WIDTH{1'b0}};
      count_q  <= {LENGTH_WIDTH{1'b0}};
      length_q <= {LENGTH_WIDTH{1'b0}};
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      length_q <= length_d;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state logic: beat placement, saturating count, length latch, handoff
  always_comb begin
    state_d    = state_q;
    buffer_d   = buffer_q;
    count_d    = count_q;
    length_d   = length_q;
    beat_acc_s = in_enq__ENA && (state_q == COLLECT);
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
    ovf_d      = ovf_q;
    if (beat_acc_s && (count_q >= LENGTH_WIDTH'(WORDS))) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
`endif
    case (state_q)
      COLLECT: begin
        if (beat_acc_s) begin
          // Beats past the last word slot match no index and are dropped
          for (int w = 0; w < WORDS; w++) begin
            buffer_d[w*BEAT_WIDTH +: BEAT_WIDTH] =
              (count_q == LENGTH_WIDTH'(w)) ? in_enq_v : buffer_q[w*BEAT_WIDTH +: BEAT_WIDTH];
          end
          count_d = (count_q == {LENGTH_WIDTH{1'b1}}) ? count_q : count_q + LENGTH_WIDTH'(1);
          if (in_enq_last) begin
            length_d = count_q;
            state_d  = HOLD;
          end else begin
            state_d  = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      HOLD: begin
        if (out_enq__RDY) begin
          buffer_d = {DATA_WIDTH{1'b0}};
          count_d  = {LENGTH_WIDTH{1'b0}};
          state_d  = COLLECT;
        end else begin
          state_d  = HOLD;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign in_enq__RDY    = (state_q == COLLECT);
  assign out_enq__ENA   = (state_q == HOLD);
  assign out_enq_v      = buffer_q;
  assign out_enq_length = length_q;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  assign overflow       = ovf_q;
`endif

endmodule

// File: tb/tb_adapter_from_bus.sv
// Scoreboard bench for adapter_from_bus: directed transfers push expected {length, word},
// a negedge monitor pops and compares on every output handshake.
module tb_adapter_from_bus;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_ena = 1'b0;
  logic [31:0]  in_v = 32'h0;
  logic         in_last = 1'b0;
  logic         in_rdy;
  logic         out_ena;
  logic [127:0] out_v;
  logic [15:0]  out_len;
  logic         out_rdy = 1'b0;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;
  logic [143:0] exp_q[$];

  adapter_from_bus dut (
    .CLK            (clk),
    .nRST           (nrst),
    .in_enq__ENA    (in_ena),
    .in_enq_v       (in_v),
    .in_enq_last    (in_last),
    .in_enq__RDY    (in_rdy),
    .out_enq__ENA   (out_ena),
    .out_enq_v      (out_v),
    .out_enq_length (out_len),
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
    .overflow       (ovf),
`endif
    .out_enq__RDY   (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat, waiting (bounded) for the adapter to be ready
  task automatic beat(input logic [31:0] v, input logic last);
    int guard = 0;
    while (!in_rdy && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("beat_ready_timeout", 128'(in_rdy), 128'(1'b1));
    in_ena  = 1'b1;
    in_v    = v;
    in_last = last;
    tick();
    in_ena  = 1'b0;
    in_last = 1'b0;
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head
  always @(negedge clk) begin
    if (nrst && out_ena && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 128'(1'b1), 128'(1'b0));
      end else begin
        logic [143:0] e;
        e = exp_q.pop_front();
        check("word_v", out_v, e[127:0]);
        check("word_len", 128'(out_len), 128'(e[143:128]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    nrst = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    check("rst_in_rdy", 128'(in_rdy), 128'(1'b1));
    check("rst_out_ena", 128'(out_ena), 128'(1'b0));
    check("rst_out_v", out_v, 128'h0);
    check("rst_out_len", 128'(out_len), 128'h0);

    // Four-beat transfer, then held off by the consumer
    exp_q.push_back({16'd3, 128'h44444444_33333333_22222222_11111111});
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    beat(32'h33333333, 1'b0);
    beat(32'h44444444, 1'b1);
    check("t1_out_ena", 128'(out_ena), 128'(1'b1));
    check("t1_v", out_v, 128'h44444444_33333333_22222222_11111111);
    check("t1_len", 128'(out_len), 128'd3);
    check("t1_in_rdy", 128'(in_rdy), 128'(1'b0));
    for (int i = 0; i < 5; i++) begin
      in_ena  = 1'b1;
      in_v    = 32'hBAD0_0000 | 32'(i);
      in_last = 1'b1;
      tick();
      check("hold_v", out_v, 128'h44444444_33333333_22222222_11111111);
      check("hold_len", 128'(out_len), 128'd3);
      check("hold_in_rdy", 128'(in_rdy), 128'(1'b0));
    end
    in_ena  = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("release_in_rdy", 128'(in_rdy), 128'(1'b1));
    check("release_out_ena", 128'(out_ena), 128'(1'b0));
    check("release_buf", out_v, 128'h0);

    // Single-beat transfer
    out_rdy = 1'b1;
    exp_q.push_back({16'd0, 128'h00000000_00000000_00000000_DEADBEEF});
    beat(32'hDEADBEEF, 1'b1);

    // Six beats: beats 5 and 6 dropped, length still counts them
    exp_q.push_back({16'd5, 128'h00000004_00000003_00000002_00000001});
    for (int i = 1; i <= 6; i++) begin
      beat(32'(i), (i == 6));
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
      if (i == 4) check("ovf_before", 128'(ovf), 128'(1'b0));
      if (i == 5) check("ovf_after", 128'(ovf), 128'(1'b1));
`endif
    end

    // Reset mid-transfer discards the partial word
    beat(32'h55, 1'b0);
    beat(32'h66, 1'b0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("midrst_in_rdy", 128'(in_rdy), 128'(1'b1));
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
    check("midrst_ovf", 128'(ovf), 128'(1'b0));
`endif
    exp_q.push_back({16'd0, 128'h0000000A});
    beat(32'hA, 1'b1);

    // Back-to-back transfers; nothing from the first may leak into the second
    exp_q.push_back({16'd1, 128'h00000000_00000000_00000102_00000101});
    exp_q.push_back({16'd2, 128'h00000000_00000203_00000202_00000201});
    beat(32'h101, 1'b0);
    beat(32'h102, 1'b1);
    beat(32'h201, 1'b0);
    beat(32'h202, 1'b0);
    beat(32'h203, 1'b1);

    // Counter saturation: 65537 beats, length sticks at all-ones
    exp_q.push_back({16'hFFFF, 128'h00000004_00000003_00000002_00000001});
    for (int i = 0; i <= 65536; i++) begin
      beat(32'(i + 1), (i == 65536));
    end

    repeat (4) tick();
    check("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
